// File: rtl/utopia_phy_tx.sv
// utopia_phy_tx: PHY-side Utopia Level 1 cell source.
//   Accepts 53-byte cells as a byte stream from an upstream generator into a
//   two-slot ping-pong store, optionally inserts the HEC byte, and presents
//   cells to the ATM layer under the cell-level clav/en handshake.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   wr_valid   upstream byte valid
//   wr_ready   a cell slot is free for writing (registered)
//   wr_data    upstream cell byte, in order 0..52
//   rx_data    Utopia cell byte to the ATM layer (registered)
//   rx_soc     high while byte 0 of a cell is on rx_data (registered)
//   rx_clav    a complete cell is held (registered)
//   rx_en      ATM-layer enable, active low; a byte transfers on an edge where it is 0
//   cells_sent count of fully transferred cells, wraps
module utopia_phy_tx #(
  parameter int unsigned CellBytes = 53,
  parameter bit          GenHec    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rx_data,
  output logic        rx_soc,
  output logic        rx_clav,
  input  logic        rx_en,
  output logic [15:0] cells_sent
);

  localparam int unsigned    IdxW    = $clog2(CellBytes);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(CellBytes - 1);
  localparam logic [IdxW-1:0] HecIdx  = IdxW'(4);
  localparam logic [IdxW-1:0] ZeroIdx = '0;

  typedef enum logic [0:0] {StIdle, StSend} tx_state_e;

  logic [7:0]      mem [2][CellBytes];
  logic [IdxW-1:0] wr_idx;
  logic [IdxW-1:0] tx_idx;
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic [1:0]      count_nxt;
  logic [7:0]      crc;
  logic [7:0]      crc_nxt;
  logic [7:0]      wr_byte;
  logic            wr_acc;
  logic            wr_done;
  logic            tx_done;
  tx_state_e       state;

  // CRC-8, x^8+x^2+x+1, MSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else                c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign wr_acc  = wr_valid & wr_ready;
  assign wr_done = wr_acc && (wr_idx == LastIdx);
  assign tx_done = (state == StSend) && !rx_en && (tx_idx == LastIdx);

  always_comb begin
    // Byte 0 restarts the CRC from zero so no explicit clear is needed per cell.
    crc_nxt   = crc8_step((wr_idx == ZeroIdx) ? 8'h00 : crc, wr_data);
    wr_byte   = (GenHec && (wr_idx == HecIdx)) ? (crc ^ 8'h55) : wr_data;
    count_nxt = count;
    if (wr_done && !tx_done)      count_nxt = count + 2'd1;
    else if (!wr_done && tx_done) count_nxt = count - 2'd1;
  end

  // Write side and cell bookkeeping. With two slots, the write slot is busy
  // exactly when both slots hold complete cells.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx   <= '0;
      wr_ptr   <= 1'b0;
      crc      <= 8'h00;
      count    <= 2'd0;
      wr_ready <= 1'b1;
      rx_clav  <= 1'b0;
    end else begin
      count    <= count_nxt;
      rx_clav  <= (count_nxt != 2'd0);
      wr_ready <= (count_nxt != 2'd2);
      if (wr_acc) begin
        if (wr_idx < HecIdx) crc <= crc_nxt;
        if (wr_done) begin
          wr_idx <= '0;
          wr_ptr <= ~wr_ptr;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
    end
  end

  // Cell storage carries no reset; stale contents are unreachable after reset
  // because the pointers and count clear.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr][wr_idx] <= wr_byte;
  end

  // Transmit FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= StIdle;
      rd_ptr     <= 1'b0;
      tx_idx     <= '0;
      rx_data    <= 8'h00;
      rx_soc     <= 1'b0;
      cells_sent <= 16'h0000;
    end else begin
      unique case (state)
        StIdle: begin
          if (count != 2'd0) begin
            rx_data <= mem[rd_ptr][ZeroIdx];
            rx_soc  <= 1'b1;
            tx_idx  <= '0;
            state   <= StSend;
          end
        end
        StSend: begin
          if (!rx_en) begin
            if (tx_idx != LastIdx) begin
              tx_idx  <= tx_idx + 1'b1;
              rx_data <= mem[rd_ptr][tx_idx + 1'b1];
              rx_soc  <= 1'b0;
            end else begin
              rd_ptr     <= ~rd_ptr;
              cells_sent <= cells_sent + 16'd1;
              tx_idx     <= '0;
              // A cell completing on this same edge has its byte 0 already
              // stored, so it can follow without a gap as well.
              if ((count == 2'd2) || wr_done) begin
                rx_data <= mem[~rd_ptr][ZeroIdx];
                rx_soc  <= 1'b1;
              end else begin
                rx_data <= 8'h00;
                rx_soc  <= 1'b0;
                state   <= StIdle;
              end
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_utopia_phy_tx.sv
// tb_utopia_phy_tx: directed self-checking bench for utopia_phy_tx.
//   dut  : GenHec=1 (HEC inserted), checked on every presented byte.
//   dut1 : GenHec=0, checked for pass-through of the written byte 4.
module tb_utopia_phy_tx;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_data;
  logic [7:0]  rx_data;
  logic        rx_soc;
  logic        rx_clav;
  logic        rx_en;
  logic [15:0] cells_sent;

  logic        wr_ready1;
  logic [7:0]  rx_data1;
  logic        rx_soc1;
  logic        rx_clav1;
  logic [15:0] cells_sent1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] cells   [7][53];
  logic [7:0] exp_hec [7];

  utopia_phy_tx #(.CellBytes(53), .GenHec(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rx_data    (rx_data),
    .rx_soc     (rx_soc),
    .rx_clav    (rx_clav),
    .rx_en      (rx_en),
    .cells_sent (cells_sent)
  );

  utopia_phy_tx #(.CellBytes(53), .GenHec(1'b0)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready1),
    .wr_data    (wr_data),
    .rx_data    (rx_data1),
    .rx_soc     (rx_soc1),
    .rx_clav    (rx_clav1),
    .rx_en      (rx_en),
    .cells_sent (cells_sent1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Header 00 00 00 hdr, written byte 4 = 0xAA, payload base..base+47.
  task automatic build(input int c, input logic [7:0] hdr, input logic [7:0] base,
                       input logic [7:0] hec);
    cells[c][0] = 8'h00;
    cells[c][1] = 8'h00;
    cells[c][2] = 8'h00;
    cells[c][3] = hdr;
    cells[c][4] = 8'hAA;
    for (int i = 0; i < 48; i++) cells[c][5+i] = base + 8'(i);
    exp_hec[c] = hec;
  endtask

  task automatic write_cells(input int first, input int n, input bit chk_full);
    int   k;
    int   wait_cyc;
    logic rdy;
    for (int c = first; c < first + n; c++) begin
      k = 0;
      wait_cyc = 0;
      while (k < 53) begin
        wr_valid = 1'b1;
        wr_data  = cells[c][k];
        rdy      = wr_ready;
        @(posedge clk); #1;
        if (rdy) k++;
        else     wait_cyc++;
        if (wait_cyc > 1000) begin
          check("wr_timeout", 32'(k), 32'd53);
          wr_valid = 1'b0;
          return;
        end
      end
      if (chk_full && (c == first + 1)) check("wr_ready_full", 32'(wr_ready), 32'd0);
    end
    wr_valid = 1'b0;
  endtask

  // Receives n cells starting at index first; stalls 5 cycles on byte
  // stall_at; returns early while byte stop_at is presented.
  task automatic recv(input int first, input int n, input int stall_at, input int stop_at,
                      input bit b2b);
    int   got;
    int   k;
    int   stall;
    int   cyc;
    bit   in_cell;
    bit   want_soc;
    logic [7:0] want;
    got = 0; k = 0; stall = 0; cyc = 0; in_cell = 1'b0; want_soc = 1'b0;
    rx_en = 1'b0;
    while ((got < n) && (cyc < 2000)) begin
      if (want_soc) begin
        check("b2b_soc", 32'(rx_soc), 32'd1);
        want_soc = 1'b0;
      end
      if (!in_cell && rx_soc) begin
        in_cell = 1'b1;
        k = 0;
      end
      if (in_cell) begin
        if (k == stop_at) return;
        rx_en = ((k == stall_at) && (stall < 5)) ? 1'b1 : 1'b0;
        if (rx_en) stall++;
        want = (k == 4) ? exp_hec[first+got] : cells[first+got][k];
        check($sformatf("data_c%0d_b%0d", first + got, k), 32'(rx_data), 32'(want));
        check($sformatf("soc_c%0d_b%0d", first + got, k), 32'(rx_soc), 32'(k == 0));
        if (k == 4) check("hec_passthru", 32'(rx_data1), 32'h0000_00AA);
        if (!rx_en) begin
          k++;
          if (k == 53) begin
            in_cell = 1'b0;
            got++;
            if (b2b && (got == 1)) want_soc = 1'b1;
          end
        end
      end else begin
        rx_en = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (got < n) check("recv_timeout", 32'(got), 32'(n));
  endtask

  initial begin
    rst      = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    rx_en    = 1'b1;

    build(0, 8'h01, 8'h00, 8'h52);
    build(1, 8'h00, 8'h40, 8'h55);
    build(2, 8'h02, 8'h10, 8'h5B);
    build(3, 8'h03, 8'h20, 8'h5C);
    build(4, 8'h04, 8'h30, 8'h49);
    build(5, 8'h01, 8'h80, 8'h52);
    build(6, 8'h03, 8'hC0, 8'h5C);

    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_soc", 32'(rx_soc), 32'd0);
    check("rst_rx_clav", 32'(rx_clav), 32'd0);
    check("rst_cells_sent", 32'(cells_sent), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_wr_ready1", 32'(wr_ready1), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single cell, rx_en held low.
    fork
      write_cells(0, 1, 1'b0);
      recv(0, 1, -1, -1, 1'b0);
    join
    check("single_clav", 32'(rx_clav), 32'd0);
    check("single_soc_idle", 32'(rx_soc), 32'd0);
    check("single_data_idle", 32'(rx_data), 32'd0);
    check("single_cells_sent", 32'(cells_sent), 32'd1);

    // All-zero header with a 5-cycle stall on byte 20.
    fork
      write_cells(1, 1, 1'b0);
      recv(1, 1, 20, -1, 1'b0);
    join
    check("stall_cells_sent", 32'(cells_sent), 32'd2);

    // Back-to-back, from a fresh reset.
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    fork
      write_cells(2, 3, 1'b1);
      recv(2, 3, -1, -1, 1'b1);
    join
    check("b2b_cells_sent", 32'(cells_sent), 32'd3);
    check("b2b_clav", 32'(rx_clav), 32'd0);

    // Asynchronous reset while byte 30 is presented.
    fork
      write_cells(5, 1, 1'b0);
      recv(5, 1, -1, 30, 1'b0);
    join
    check("pre_rst_clav", 32'(rx_clav), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rx_data", 32'(rx_data), 32'd0);
    check("async_rx_soc", 32'(rx_soc), 32'd0);
    check("async_rx_clav", 32'(rx_clav), 32'd0);
    check("async_cells_sent", 32'(cells_sent), 32'd0);
    check("async_wr_ready", 32'(wr_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    fork
      write_cells(6, 1, 1'b0);
      recv(6, 1, -1, -1, 1'b0);
    join
    check("post_rst_cells_sent", 32'(cells_sent), 32'd1);
    check("post_rst_clav", 32'(rx_clav), 32'd0);
    check("dut1_cells_sent", 32'(cells_sent1), 32'd1);
    check("dut1_clav", 32'(rx_clav1), 32'd0);
    check("dut1_soc", 32'(rx_soc1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
